io_pad_poller: RTL and testbench

IO_PAD_POLLER -- requirements
Module: io_pad_poller

---
 rtl/io_pad_poller.sv | 255 +++++++++++++++++++++++++
 tb/tb_io_pad_poller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/io_pad_poller.sv
// Polls NUM_CONT pad controllers over a 1-wire line and publishes each complete frame in one cycle.
// Build option: define CHANGE_DETECT_EN to produce per-controller change flags with frame_valid.
module io_pad_poller #(
   parameter int NUM_CONT    = 4,
   parameter int BITLEN      = 60,
   parameter int POLL_PERIOD = 65536,
   parameter int HB_PERIOD   = 524288,
   parameter int RX_TIMEOUT  = 2097152
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    pad_i,
   output logic                    pad_o,
   output logic                    pad_oe,
   output logic [32*NUM_CONT-1:0]  cont_key,
   output logic [32*NUM_CONT-1:0]  cont_joy,
   output logic [16*NUM_CONT-1:0]  cont_trig,
   output logic                    frame_valid,
   output logic [NUM_CONT-1:0]     cont_changed,
   output logic                    rx_timed_out
);

   localparam int CW   = (BITLEN > 256) ? $clog2(BITLEN) : 9;
   localparam int PW   = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
   localparam int HW   = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
   localparam int TW   = (RX_TIMEOUT > 2) ? $clog2(RX_TIMEOUT) : 2;
   localparam int CTLW = (NUM_CONT > 1) ? $clog2(NUM_CONT) : 1;

   localparam logic [CW-1:0]   WAIT_LAST = CW'(255);
   localparam logic [CW-1:0]   BIT_LAST  = CW'(BITLEN - 1);
   localparam logic [CW-1:0]   THIRD     = CW'(BITLEN / 3);
   localparam logic [CW-1:0]   TWO_THIRD = CW'(2 * BITLEN / 3);
   localparam logic [CW-1:0]   SMP_LAST  = CW'(BITLEN / 2 - 5);
   localparam logic [PW-1:0]   POLL_LAST = PW'(POLL_PERIOD - 1);
   localparam logic [HW-1:0]   HB_LAST   = HW'(HB_PERIOD - 1);
   localparam logic [TW-1:0]   TMO_LAST  = TW'(RX_TIMEOUT - 1);
   localparam logic [TW-1:0]   HOLD_LAST = TW'(RX_TIMEOUT / 2 - 1);
   localparam logic [CTLW-1:0] CTL_LAST  = CTLW'(NUM_CONT - 1);
   localparam logic [31:0]     POLL_WORD = 32'h4A10_0000 | 32'(3 * NUM_CONT);
   localparam logic [31:0]     HB_WORD   = 32'h4AFE_0000;

   typedef enum logic [2:0] {RESET, IDLE, TX_POLL, RX_WORDS, TX_HB} state_t;
   typedef enum logic [1:0] {TX_WAIT, TX_START, TX_BITS} tx_ph_t;

   state_t                    state;
   tx_ph_t                    tx_ph;
   logic [2:0]                sync_q;
   logic [PW-1:0]             poll_cnt;
   logic [HW-1:0]             hb_cnt;
   logic                      poll_pending, hb_pending;
   logic [TW-1:0]             tmo_cnt;
   logic [CW-1:0]             tx_cnt, rx_cnt;
   logic [4:0]                bit_idx, rx_bits;
   logic [31:0]               tx_sh, rx_sh;
   logic                      rx_busy, commit;
   logic [CTLW-1:0]           w_ctl;
   logic [1:0]                w_slot;
   logic [NUM_CONT-1:0][31:0] sh_key, sh_joy, key_q, joy_q;
   logic [NUM_CONT-1:0][15:0] sh_trig, trig_q;
   logic [NUM_CONT-1:0]       chg;
   logic                      fall;
   logic [31:0]               rx_word;

   // sync_q[1] is the synchronised line; sync_q[2] is its previous value for edge detection
   assign fall    = sync_q[2] & ~sync_q[1];
   assign rx_word = {rx_sh[30:0], sync_q[1]};

   assign cont_key  = key_q;
   assign cont_joy  = joy_q;
   assign cont_trig = trig_q;

`ifdef CHANGE_DETECT_EN
   for (genvar n = 0; n < NUM_CONT; n++) begin : g_chg
      assign chg[n] = (sh_key[n] != key_q[n]) || (sh_joy[n] != joy_q[n]) ||
                      (sh_trig[n] != trig_q[n]);
   end
`else
   assign chg = '0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= RESET;
         tx_ph        <= TX_WAIT;
         sync_q       <= 3'b111;
         poll_cnt     <= '0;
         hb_cnt       <= '0;
         poll_pending <= 1'b0;
         hb_pending   <= 1'b0;
         tmo_cnt      <= '0;
         tx_cnt       <= '0;
         rx_cnt       <= '0;
         bit_idx      <= 5'd31;
         rx_bits      <= '0;
         tx_sh        <= '0;
         rx_sh        <= '0;
         rx_busy      <= 1'b0;
         commit       <= 1'b0;
         w_ctl        <= '0;
         w_slot       <= '0;
         sh_key       <= '0;
         sh_joy       <= '0;
         sh_trig      <= '0;
         key_q        <= '0;
         joy_q        <= '0;
         trig_q       <= '0;
         pad_o        <= 1'b1;
         pad_oe       <= 1'b0;
         frame_valid  <= 1'b0;
         cont_changed <= '0;
         rx_timed_out <= 1'b0;
      end else begin
         sync_q       <= {sync_q[1:0], pad_i};
         pad_oe       <= 1'b0;
         pad_o        <= 1'b1;
         frame_valid  <= 1'b0;
         cont_changed <= '0;

         case (state)
            RESET: begin
               if (tmo_cnt == HOLD_LAST) begin
                  state        <= IDLE;
                  tmo_cnt      <= '0;
                  rx_timed_out <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            IDLE: begin
               tmo_cnt <= '0;
               tx_ph   <= TX_WAIT;
               tx_cnt  <= '0;
               bit_idx <= 5'd31;
               rx_busy <= 1'b0;
               rx_bits <= '0;
               commit  <= 1'b0;
               w_ctl   <= '0;
               w_slot  <= '0;
               if (poll_pending) begin
                  poll_pending <= 1'b0;
                  tx_sh        <= POLL_WORD;
                  state        <= TX_POLL;
               end else if (hb_pending) begin
                  hb_pending <= 1'b0;
                  tx_sh      <= HB_WORD;
                  state      <= TX_HB;
               end
            end

            default: begin
               if (tmo_cnt == TMO_LAST) begin
                  // link stuck: drop whatever partial frame was collected
                  state        <= RESET;
                  tmo_cnt      <= '0;
                  rx_timed_out <= 1'b1;
                  commit       <= 1'b0;
                  rx_busy      <= 1'b0;
                  sh_key       <= '0;
                  sh_joy       <= '0;
                  sh_trig      <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  if (state == RX_WORDS) begin
                     if (commit) begin
                        key_q        <= sh_key;
                        joy_q        <= sh_joy;
                        trig_q       <= sh_trig;
                        frame_valid  <= 1'b1;
                        cont_changed <= chg;
                        commit       <= 1'b0;
                        state        <= IDLE;
                     end else if (!rx_busy) begin
                        if (fall) begin
                           rx_busy <= 1'b1;
                           rx_cnt  <= '0;
                        end
                     end else if (rx_cnt != SMP_LAST) begin
                        rx_cnt <= rx_cnt + 1'b1;
                     end else begin
                        rx_busy <= 1'b0;
                        rx_sh   <= rx_word;
                        rx_bits <= rx_bits + 1'b1;
                        if (rx_bits == 5'd31) begin
                           case (w_slot)
                              2'd0:    sh_key[w_ctl]  <= rx_word;
                              2'd1:    sh_joy[w_ctl]  <= rx_word;
                              default: sh_trig[w_ctl] <= rx_word[15:0];
                           endcase
                           if (w_slot == 2'd2) begin
                              w_slot <= '0;
                              if (w_ctl == CTL_LAST) commit <= 1'b1;
                              else                   w_ctl  <= w_ctl + 1'b1;
                           end else begin
                              w_slot <= w_slot + 1'b1;
                           end
                        end
                     end
                  end else begin
                     case (tx_ph)
                        TX_WAIT: begin
                           if (tx_cnt == WAIT_LAST) begin
                              tx_cnt <= '0;
                              tx_ph  <= TX_START;
                           end else begin
                              tx_cnt <= tx_cnt + 1'b1;
                           end
                        end
                        TX_START: begin
                           pad_oe <= 1'b1;
                           pad_o  <= 1'b1;
                           if (tx_cnt == BIT_LAST) begin
                              tx_cnt <= '0;
                              tx_ph  <= TX_BITS;
                           end else begin
                              tx_cnt <= tx_cnt + 1'b1;
                           end
                        end
                        default: begin
                           pad_oe <= 1'b1;
                           pad_o  <= (tx_cnt < THIRD)     ? 1'b0 :
                                     (tx_cnt < TWO_THIRD) ? tx_sh[31] : 1'b1;
                           if (tx_cnt == BIT_LAST) begin
                              tx_cnt  <= '0;
                              tx_sh   <= tx_sh << 1;
                              bit_idx <= bit_idx - 1'b1;
                              if (bit_idx == 5'd0)
                                 state <= (state == TX_POLL) ? RX_WORDS : IDLE;
                           end else begin
                              tx_cnt <= tx_cnt + 1'b1;
                           end
                        end
                     endcase
                  end
               end
            end
         endcase

         // period ticks come last so a fresh tick wins over a same-cycle clear
         if (poll_cnt == POLL_LAST) begin
            poll_cnt     <= '0;
            poll_pending <= 1'b1;
         end else begin
            poll_cnt <= poll_cnt + 1'b1;
         end
         if (hb_cnt == HB_LAST) begin
            hb_cnt     <= '0;
            hb_pending <= 1'b1;
         end else begin
            hb_cnt <= hb_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_io_pad_poller.sv
// Directed bench for io_pad_poller: decodes the transmitted line, plays a controller reply model.
module tb_io_pad_poller;
   localparam int BL = 12;
`ifdef CHANGE_DETECT_EN
   localparam bit CD = 1'b1;
`else
   localparam bit CD = 1'b0;
`endif

   logic        clk = 1'b0, reset = 1'b1, bus_drv = 1'b1;
   logic        pad_i, pad_o, pad_oe, frame_valid, rx_timed_out;
   logic [63:0] cont_key, cont_joy;
   logic [31:0] cont_trig;
   logic [1:0]  cont_changed;
   int          n_chk = 0, n_fail = 0, fv_cnt = 0;
   logic [1:0]  fv_chg = '0;

   assign pad_i = pad_oe ? pad_o : bus_drv;

   io_pad_poller #(.NUM_CONT(2), .BITLEN(BL), .POLL_PERIOD(4096), .HB_PERIOD(16384),
                   .RX_TIMEOUT(8192)) dut (
      .clk(clk), .reset(reset), .pad_i(pad_i), .pad_o(pad_o), .pad_oe(pad_oe),
      .cont_key(cont_key), .cont_joy(cont_joy), .cont_trig(cont_trig),
      .frame_valid(frame_valid), .cont_changed(cont_changed), .rx_timed_out(rx_timed_out));

   always #5 clk = ~clk;

   always @(negedge clk) if (!reset && frame_valid) begin
      fv_cnt = fv_cnt + 1;
      fv_chg = cont_changed;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Decode one transmission: start-high length, 32 bit cells, and cell shape.
   task automatic get_tx(output logic [31:0] w, output int start_len, output logic shape_ok,
                         output logic seen);
      logic [BL-1:0] v;
      int k;
      w = '0; start_len = 0; shape_ok = 1'b1; seen = 1'b0; k = 0;
      while (!pad_oe && k < 6000) begin @(negedge clk); k++; end
      if (!pad_oe) return;
      seen = 1'b1;
      while (pad_oe && pad_o && start_len < 300) begin start_len++; @(negedge clk); end
      for (int b = 31; b >= 0; b--) begin
         for (int j = 0; j < BL; j++) begin
            if (!pad_oe) shape_ok = 1'b0;
            v[j] = pad_o;
            @(negedge clk);
         end
         w[b] = v[6];
         if (v[3:0] != 4'h0 || v[7:4] != {4{v[6]}} || v[11:8] != 4'hF) shape_ok = 1'b0;
      end
   endtask

   // Reply cells carry data from the second cycle so the receiver's early sample point lands on it.
   task automatic send_word(input logic [31:0] w);
      for (int b = 31; b >= 0; b--)
         for (int j = 0; j < BL; j++) begin
            bus_drv = (j == 0) ? 1'b0 : (w[b] ? 1'b1 : (j < 8 ? 1'b0 : 1'b1));
            @(negedge clk);
         end
      bus_drv = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_frame(input logic [191:0] f, input int n);
      repeat (8) @(negedge clk);
      for (int i = 0; i < n; i++) send_word(f[191-32*i -: 32]);
      repeat (20) @(negedge clk);
   endtask

   initial begin
      logic [31:0] w;
      int          sl, k;
      logic        sh, seen;

      repeat (4) @(negedge clk);
      chk("rst_pad_oe", pad_oe, 0);
      chk("rst_pad_o", pad_o, 1);
      chk("rst_key", cont_key, 0);
      chk("rst_joy", cont_joy, 0);
      chk("rst_trig", cont_trig, 0);
      chk("rst_fv", frame_valid, 0);
      chk("rst_chg", cont_changed, 0);
      chk("rst_tmo", rx_timed_out, 0);
      reset = 1'b0;
      repeat (4000) @(negedge clk);
      chk("hold_released", pad_oe, 0);

      get_tx(w, sl, sh, seen);
      chk("poll1_seen", seen, 1);
      chk("poll1_word", w, 32'h4A10_0006);
      chk("poll1_start_len", sl, BL);
      chk("poll1_shape", sh, 1);
      chk("poll1_release", pad_oe, 0);
      send_frame({32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'hABCD_1234}, 6);
      chk("f1_fv_cnt", fv_cnt, 1);
      chk("f1_key", cont_key, 64'h0000_0044_0000_0011);
      chk("f1_joy", cont_joy, 64'h0000_0055_0000_0022);
      chk("f1_trig", cont_trig, 32'h1234_0033);
      chk("f1_chg", fv_chg, CD ? 2'b11 : 2'b00);

      get_tx(w, sl, sh, seen);
      chk("poll2_word", w, 32'h4A10_0006);
      send_frame({32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'hABCD_1234}, 6);
      chk("f2_fv_cnt", fv_cnt, 2);
      chk("f2_chg", fv_chg, 2'b00);
      chk("f2_key", cont_key, 64'h0000_0044_0000_0011);

      get_tx(w, sl, sh, seen);
      chk("poll3_word", w, 32'h4A10_0006);
      send_frame({32'h11, 32'h22, 32'h33, 32'h44, 32'h66, 32'hABCD_1234}, 6);
      chk("f3_fv_cnt", fv_cnt, 3);
      chk("f3_chg", fv_chg, CD ? 2'b10 : 2'b00);
      chk("f3_joy", cont_joy, 64'h0000_0066_0000_0022);

      // poll and heartbeat become pending on the same cycle here
      get_tx(w, sl, sh, seen);
      chk("poll4_word", w, 32'h4A10_0006);
      send_frame({32'hA1, 32'hA2, 32'hA3, 32'hB1, 32'hB2, 32'hC0DE_BEEF}, 6);
      chk("f4_fv_cnt", fv_cnt, 4);
      chk("f4_key", cont_key, 64'h0000_00B1_0000_00A1);
      chk("f4_trig", cont_trig, 32'hBEEF_00A3);
      get_tx(w, sl, sh, seen);
      chk("hb_seen", seen, 1);
      chk("hb_word", w, 32'h4AFE_0000);
      chk("hb_shape", sh, 1);
      chk("hb_release", pad_oe, 0);

      get_tx(w, sl, sh, seen);
      chk("poll5_word", w, 32'h4A10_0006);
      send_frame({32'h01, 32'h02, 32'h03, 32'h04, 32'h05, 32'h06}, 3);
      k = 0;
      while (!rx_timed_out && k < 10000) begin @(negedge clk); k++; end
      chk("tmo_flag", rx_timed_out, 1);
      chk("tmo_no_fv", fv_cnt, 4);
      chk("tmo_key_kept", cont_key, 64'h0000_00B1_0000_00A1);
      chk("tmo_joy_kept", cont_joy, 64'h0000_00B2_0000_00A2);
      chk("tmo_trig_kept", cont_trig, 32'hBEEF_00A3);

      k = 0;
      while (!pad_oe && k < 6000) begin @(negedge clk); k++; end
      chk("post_tmo_tx", pad_oe, 1);
      chk("tmo_cleared", rx_timed_out, 0);
      k = 0;
      while (pad_o && k < 100) begin @(negedge clk); k++; end
      repeat (2) @(negedge clk);
      chk("pre_reset_drive", pad_oe, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_pad_oe", pad_oe, 0);
      chk("mid_rst_pad_o", pad_o, 1);
      chk("mid_rst_key", cont_key, 0);
      chk("mid_rst_joy", cont_joy, 0);
      chk("mid_rst_trig", cont_trig, 0);
      chk("mid_rst_fv", frame_valid, 0);
      chk("mid_rst_tmo", rx_timed_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
